// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants, fetch FSM states and IF/ID bundle type
//
// Purpose : common definitions for the RV64 pipeline front end.
// Contents: XLEN, RESET_PC, NOP_INSTR, fetch_state_t, if_id_t.

package riscv_pkg;

   localparam int              XLEN      = 64;
   localparam logic [XLEN-1:0] RESET_PC  = '0;
   localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [31:0]     instr;
   } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load/hold/flush controls
//
// Purpose : holds one fetched instruction bundle between IF and ID.
// Ports   : clk_i, rst_i    clock, async active-high reset
//           load_i          capture d_i
//           flush_i         insert a bubble (wins over load_i)
//           d_i             incoming bundle
//           q_o             registered bundle
// Neither load_i nor flush_i asserted means hold.

module if_id_reg
   import riscv_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic   clk_i,
   input  logic   rst_i,
   input  logic   load_i,
   input  logic   flush_i,
   input  if_id_t d_i,
   output if_id_t q_o
);

   if_id_t q_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         q_q.valid    <= 1'b0;
         q_q.pc       <= '0;
         q_q.pc_plus4 <= '0;
         q_q.instr    <= NOP_INSTR;
      end else if (flush_i) begin
         // A bubble only needs valid and instr cleared; the pc fields are
         // don't-care downstream while valid is low.
         q_q.valid <= 1'b0;
         q_q.instr <= NOP_INSTR;
      end else if (load_i) begin
         q_q <= d_i;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - RV64 instruction-fetch stage: PC, next-PC mux, FSM, counter
//
// Purpose : owns the PC, drives instruction memory, fills IF/ID.
// Ports   : clk, rst                    clock, async active-high reset
//           imem_addr / imem_instr      fetch address (= pc) / returned word
//           stall                       hold PC and IF/ID
//           redirect_valid/redirect_pc  resolved taken branch/jump target
//           if_id_valid/pc/pc_plus4/instr  IF/ID register contents
//           fetch_fault / fault_pc      misaligned redirect captured
//           fetch_count                 valid instructions delivered to IF/ID
// The IF/ID bundle type is sized by riscv_pkg::XLEN; keep XLEN at its default.

module fetch_stage
   import riscv_pkg::*;
#(
   parameter int              XLEN      = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = riscv_pkg::RESET_PC,
   parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_instr,
   input  logic            stall,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            if_id_valid,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pc_plus4,
   output logic [31:0]     if_id_instr,
   output logic            fetch_fault,
   output logic [XLEN-1:0] fault_pc,
   output logic [63:0]     fetch_count
);

   fetch_state_t    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            fault_q, fault_d;
   logic [XLEN-1:0] fault_pc_q, fault_pc_d;
   logic [63:0]     count_q, count_d;

   logic            ifid_load;
   logic            ifid_flush;
   logic [XLEN-1:0] pc_plus4;
   logic            target_aligned;
   if_id_t          ifid_d;
   if_id_t          ifid_q;

   // Wraps modulo 2^XLEN by construction.
   assign pc_plus4       = pc_q + XLEN'(4);
   assign target_aligned = (redirect_pc[1:0] == 2'b00);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         fault_q    <= 1'b0;
         fault_pc_q <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         fault_q    <= fault_d;
         fault_pc_q <= fault_pc_d;
         count_q    <= count_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      fault_d    = fault_q;
      fault_pc_d = fault_pc_q;
      count_d    = count_q;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;

      unique case (state_q)
         BOOT: begin
            // One bubble after reset release; stall/redirect not yet trusted.
            ifid_flush = 1'b1;
            state_d    = RUN;
         end
         RUN: begin
            if (redirect_valid) begin
               // Flush even under stall: the instruction in IF/ID is wrong-path.
               ifid_flush = 1'b1;
               if (target_aligned) begin
                  pc_d = redirect_pc;
               end else begin
                  fault_d    = 1'b1;
                  fault_pc_d = redirect_pc;
                  state_d    = FAULT;
               end
            end else if (!stall) begin
               ifid_load = 1'b1;
               pc_d      = pc_plus4;
               count_d   = count_q + 64'd1;
            end
         end
         FAULT: begin
            ifid_flush = 1'b1;
            if (redirect_valid) begin
               if (target_aligned) begin
                  pc_d    = redirect_pc;
                  fault_d = 1'b0;
                  state_d = RUN;
               end else begin
                  fault_pc_d = redirect_pc;
               end
            end
         end
         default: begin
            ifid_flush = 1'b1;
            state_d    = BOOT;
         end
      endcase
   end

   always_comb begin
      ifid_d.valid    = 1'b1;
      ifid_d.pc       = pc_q;
      ifid_d.pc_plus4 = pc_plus4;
      ifid_d.instr    = imem_instr;
   end

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .clk_i   (clk),
      .rst_i   (rst),
      .load_i  (ifid_load),
      .flush_i (ifid_flush),
      .d_i     (ifid_d),
      .q_o     (ifid_q)
   );

   assign imem_addr      = pc_q;
   assign if_id_valid    = ifid_q.valid;
   assign if_id_pc       = ifid_q.pc;
   assign if_id_pc_plus4 = ifid_q.pc_plus4;
   assign if_id_instr    = ifid_q.instr;
   assign fetch_fault    = fault_q;
   assign fault_pc       = fault_pc_q;
   assign fetch_count    = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage

module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam int K_BUB  = 0;
   localparam int K_LD   = 1;
   localparam int K_HOLD = 2;
   localparam int NVEC   = 20;

   logic        clk;
   logic        rst;
   logic [63:0] imem_addr;
   logic [31:0] imem_instr;
   logic        stall;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        if_id_valid;
   logic [63:0] if_id_pc;
   logic [63:0] if_id_pc_plus4;
   logic [31:0] if_id_instr;
   logic        fetch_fault;
   logic [63:0] fault_pc;
   logic [63:0] fetch_count;

   typedef struct {
      logic        stall;
      logic        rv;
      logic [63:0] rpc;
      int          kind;
      logic [63:0] e_pc;
      logic        e_fault;
      logic [63:0] e_fpc;
      logic [63:0] e_cnt;
   } vec_t;

   typedef struct {
      logic [63:0] pc;
      logic [63:0] pc4;
      logic [31:0] instr;
   } exp_t;

   vec_t        tbl [NVEC];
   exp_t        sb_q [$];
   exp_t        last_rec;
   logic [63:0] prev_pc;
   int          n_pass;
   int          n_total;

   fetch_stage dut (
      .clk            (clk),
      .rst            (rst),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .if_id_valid    (if_id_valid),
      .if_id_pc       (if_id_pc),
      .if_id_pc_plus4 (if_id_pc_plus4),
      .if_id_instr    (if_id_instr),
      .fetch_fault    (fetch_fault),
      .fault_pc       (fault_pc),
      .fetch_count    (fetch_count)
   );

   function automatic logic [31:0] imem_f(input logic [63:0] a);
      if (a == 64'h0)      return 32'h0050_0093;
      else if (a == 64'h4) return 32'h00A0_0113;
      else                 return {a[29:0], 2'b11};
   endfunction

   assign imem_instr = imem_f(imem_addr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h required %h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic s, input logic rv, input logic [63:0] rpc,
                               input int kind, input logic [63:0] e_pc, input logic e_fault,
                               input logic [63:0] e_fpc, input logic [63:0] e_cnt);
      vec_t v;
      v.stall = s; v.rv = rv; v.rpc = rpc; v.kind = kind; v.e_pc = e_pc;
      v.e_fault = e_fault; v.e_fpc = e_fpc; v.e_cnt = e_cnt;
      return v;
   endfunction

   task automatic check_reset_values(input string tag);
      chk({tag, "_valid"},  {63'd0, if_id_valid}, 64'd0);
      chk({tag, "_pc"},     if_id_pc, 64'd0);
      chk({tag, "_pc4"},    if_id_pc_plus4, 64'd0);
      chk({tag, "_instr"},  {32'd0, if_id_instr}, {32'd0, NOP});
      chk({tag, "_fault"},  {63'd0, fetch_fault}, 64'd0);
      chk({tag, "_fpc"},    fault_pc, 64'd0);
      chk({tag, "_count"},  fetch_count, 64'd0);
      chk({tag, "_imem"},   imem_addr, 64'd0);
   endtask

   task automatic apply(input int i);
      vec_t v;
      exp_t e;
      exp_t got;
      string t;
      v = tbl[i];
      t = $sformatf("v%0d", i);
      stall          = v.stall;
      redirect_valid = v.rv;
      redirect_pc    = v.rpc;
      if (v.kind == K_LD) begin
         e.pc    = prev_pc;
         e.pc4   = prev_pc + 64'd4;
         e.instr = imem_f(prev_pc);
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      stall          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      chk({t, "_imem"},  imem_addr, v.e_pc);
      chk({t, "_fault"}, {63'd0, fetch_fault}, {63'd0, v.e_fault});
      chk({t, "_fpc"},   fault_pc, v.e_fpc);
      chk({t, "_count"}, fetch_count, v.e_cnt);
      if (v.kind == K_BUB) begin
         chk({t, "_bub_valid"}, {63'd0, if_id_valid}, 64'd0);
         chk({t, "_bub_instr"}, {32'd0, if_id_instr}, {32'd0, NOP});
      end else begin
         if (v.kind == K_LD) begin
            if (sb_q.size() == 0) begin
               n_total++;
               $display("FAIL %s_sb: got empty scoreboard required entry", t);
               got = last_rec;
            end else begin
               got = sb_q.pop_front();
            end
            last_rec = got;
         end else begin
            got = last_rec;
         end
         chk({t, "_valid"}, {63'd0, if_id_valid}, 64'd1);
         chk({t, "_pc"},    if_id_pc, got.pc);
         chk({t, "_pc4"},   if_id_pc_plus4, got.pc4);
         chk({t, "_instr"}, {32'd0, if_id_instr}, {32'd0, got.instr});
      end
      prev_pc = v.e_pc;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      prev_pc = 64'd0;
      last_rec = '{pc: 64'd0, pc4: 64'd0, instr: NOP};

      //               stall rv  rpc                     kind    e_pc                    flt e_fpc    e_cnt
      tbl[0]  = mk(1'b1, 1'b1, 64'h80,                K_BUB,  64'h0,                  0, 64'h0,  64'd0); // BOOT ignores both
      tbl[1]  = mk(1'b0, 1'b0, 64'h0,                 K_LD,   64'h4,                  0, 64'h0,  64'd1);
      tbl[2]  = mk(1'b0, 1'b0, 64'h0,                 K_LD,   64'h8,                  0, 64'h0,  64'd2);
      tbl[3]  = mk(1'b1, 1'b0, 64'h0,                 K_HOLD, 64'h8,                  0, 64'h0,  64'd2);
      tbl[4]  = mk(1'b1, 1'b0, 64'h0,                 K_HOLD, 64'h8,                  0, 64'h0,  64'd2);
      tbl[5]  = mk(1'b1, 1'b0, 64'h0,                 K_HOLD, 64'h8,                  0, 64'h0,  64'd2);
      tbl[6]  = mk(1'b0, 1'b0, 64'h0,                 K_LD,   64'hC,                  0, 64'h0,  64'd3);
      tbl[7]  = mk(1'b0, 1'b0, 64'h0,                 K_LD,   64'h10,                 0, 64'h0,  64'd4);
      tbl[8]  = mk(1'b1, 1'b1, 64'h40,                K_BUB,  64'h40,                 0, 64'h0,  64'd4);
      tbl[9]  = mk(1'b0, 1'b0, 64'h0,                 K_LD,   64'h44,                 0, 64'h0,  64'd5);
      tbl[10] = mk(1'b0, 1'b1, 64'h42,                K_BUB,  64'h44,                 1, 64'h42, 64'd5);
      tbl[11] = mk(1'b0, 1'b0, 64'h0,                 K_BUB,  64'h44,                 1, 64'h42, 64'd5);
      tbl[12] = mk(1'b1, 1'b0, 64'h0,                 K_BUB,  64'h44,                 1, 64'h42, 64'd5);
      tbl[13] = mk(1'b0, 1'b1, 64'h47,                K_BUB,  64'h44,                 1, 64'h47, 64'd5);
      tbl[14] = mk(1'b0, 1'b1, 64'h100,               K_BUB,  64'h100,                0, 64'h47, 64'd5);
      tbl[15] = mk(1'b0, 1'b0, 64'h0,                 K_LD,   64'h104,                0, 64'h47, 64'd6);
      tbl[16] = mk(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, K_BUB, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h47, 64'd6);
      tbl[17] = mk(1'b0, 1'b0, 64'h0,                 K_LD,   64'h0,                  0, 64'h47, 64'd7);
      tbl[18] = mk(1'b0, 1'b0, 64'h0,                 K_LD,   64'h4,                  0, 64'h47, 64'd8);
      tbl[19] = mk(1'b0, 1'b1, 64'h20,                K_BUB,  64'h20,                 0, 64'h47, 64'd8);

      rst = 1'b0;
      #1 rst = 1'b1;
      #2;
      check_reset_values("rst0");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) apply(i);

      // Wrap case: IF/ID pc_plus4 for the instruction at FFFF_FFFF_FFFF_FFFC is 0,
      // covered by tbl[17] through the scoreboard entry.

      // Asynchronous reset between clock edges while pc==0x20.
      #3 rst = 1'b1;
      #1;
      check_reset_values("rst_mid");
      @(negedge clk);
      rst = 1'b0;
      prev_pc = 64'd0;
      last_rec = '{pc: 64'd0, pc4: 64'd0, instr: NOP};
      for (int i = 0; i < 3; i++) apply(i);

      n_total++;
      if (sb_q.size() == 0) n_pass++;
      else $display("FAIL sb_drain: got %0d entries required 0", sb_q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
